// File: rtl/b01_pkg.sv
// Shared defaults and holding-FSM state type for the serial sum collector.
package b01_pkg;

  localparam int unsigned WidthDefault = 8;
  localparam int unsigned CntWDefault  = 8;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/ovf_sat_counter.sv
// Saturating up-counter of words loaded with their overflow summary set.
module ovf_sat_counter
  import b01_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/serial_sum_collector.sv
// Collects a serial sum stream LSB first into words and holds them for a ready/valid consumer.
// Define OVF_COUNT_EN to add the saturating ovf_count output.
module serial_sum_collector
  import b01_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sin,
  input  logic             ovf_in,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             word_ovf,
  output logic             lost
`ifdef OVF_COUNT_EN
  ,
  output logic [CNT_W-1:0] ovf_count
`endif
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             acc_q, acc_d;

  logic [IdxW-1:0]  base_idx;
  logic [WIDTH-1:0] base_word;
  logic             base_acc;
  logic [WIDTH-1:0] cur_word;
  logic             cur_acc;
  logic             complete;

  hold_state_e      state_q, state_d;
  logic [WIDTH-1:0] hold_word_q, hold_word_d;
  logic             hold_ovf_q, hold_ovf_d;
  logic             lost_q, lost_d;
  logic             load;

  // frame_start discards the partial word before this cycle's bit is placed.
  always_comb begin
    base_idx  = frame_start ? '0 : idx_q;
    base_word = frame_start ? '0 : shift_q;
    base_acc  = frame_start ? 1'b0 : acc_q;

    cur_word = base_word;
    if (sin_valid) begin
      cur_word[base_idx] = sin;
    end
    cur_acc  = base_acc | (sin_valid & ovf_in);
    complete = sin_valid && (base_idx == LastIdx);

    idx_d   = base_idx;
    shift_d = base_word;
    acc_d   = base_acc;
    if (sin_valid) begin
      if (complete) begin
        idx_d   = '0;
        shift_d = '0;
        acc_d   = 1'b0;
      end else begin
        idx_d   = base_idx + IdxW'(1);
        shift_d = cur_word;
        acc_d   = cur_acc;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_word_d = hold_word_q;
    hold_ovf_d  = hold_ovf_q;
    lost_d      = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      StEmpty: begin
        load = complete;
      end
      StFull: begin
        if (complete) begin
          load   = word_ready;
          lost_d = ~word_ready;
        end else if (word_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase

    if (load) begin
      state_d     = StFull;
      hold_word_d = cur_word;
      hold_ovf_d  = cur_acc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q       <= '0;
      shift_q     <= '0;
      acc_q       <= 1'b0;
      state_q     <= StEmpty;
      hold_word_q <= '0;
      hold_ovf_q  <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      state_q     <= state_d;
      hold_word_q <= hold_word_d;
      hold_ovf_q  <= hold_ovf_d;
      lost_q      <= lost_d;
    end
  end

  assign word_out   = hold_word_q;
  assign word_ovf   = hold_ovf_q;
  assign word_valid = (state_q == StFull);
  assign lost       = lost_q;

`ifdef OVF_COUNT_EN
  ovf_sat_counter #(
    .CNT_W(CNT_W)
  ) u_ovf_sat_counter (
    .clock(clock),
    .reset(reset),
    .inc  (load & cur_acc),
    .count(ovf_count)
  );
`endif

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed bench for serial_sum_collector with a word-level reference model checked every cycle.
module tb_serial_sum_collector;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;
  localparam int MaxCnt = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             sin, ovf_in, sin_valid, frame_start, word_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid, word_ovf, lost;
  logic [CNT_W-1:0] ovf_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int valid_cycles = 0;

  // Reference model state: bits collected so far as a count plus arithmetic value.
  int               m_n;
  logic [WIDTH-1:0] m_v;
  logic             m_o;
  logic             m_valid, m_wovf, m_lost;
  logic [WIDTH-1:0] m_word;
  int               m_count;

  serial_sum_collector #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sin        (sin),
    .ovf_in     (ovf_in),
    .sin_valid  (sin_valid),
    .frame_start(frame_start),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_ovf   (word_ovf),
    .lost       (lost)
`ifdef OVF_COUNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

`ifndef OVF_COUNT_EN
  assign ovf_count = '0;
`endif

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin : model
    int n;
    logic [WIDTH-1:0] v, w;
    logic o, wo, done;
    n = m_n; v = m_v; o = m_o; done = 1'b0; w = '0; wo = 1'b0;
    if (reset) begin
      m_n <= 0; m_v <= '0; m_o <= 1'b0;
      m_valid <= 1'b0; m_word <= '0; m_wovf <= 1'b0; m_lost <= 1'b0; m_count <= 0;
    end else begin
      if (frame_start) begin
        n = 0; v = '0; o = 1'b0;
      end
      if (sin_valid) begin
        v = v + (WIDTH'(sin) << n);
        o = o | ovf_in;
        n = n + 1;
        if (n == WIDTH) begin
          done = 1'b1; w = v; wo = o; n = 0; v = '0; o = 1'b0;
        end
      end
      m_n <= n; m_v <= v; m_o <= o;
      m_lost <= done && m_valid && !word_ready;
      if (done && (!m_valid || word_ready)) begin
        m_valid <= 1'b1;
        m_word  <= w;
        m_wovf  <= wo;
        if (wo && m_count < MaxCnt) m_count <= m_count + 1;
      end else if (m_valid && word_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model word_valid", 32'(word_valid), 32'(m_valid));
      check("model lost", 32'(lost), 32'(m_lost));
      if (m_valid) begin
        check("model word_out", 32'(word_out), 32'(m_word));
        check("model word_ovf", 32'(word_ovf), 32'(m_wovf));
      end
`ifdef OVF_COUNT_EN
      check("model ovf_count", 32'(ovf_count), 32'(m_count));
`endif
      if (word_valid) valid_cycles <= valid_cycles + 1;
    end
  end

  // Drives one cycle of inputs and returns at the following negedge.
  task automatic cyc(input logic v, input logic b, input logic o, input logic fs,
                     input logic rdy);
    sin_valid = v; sin = b; ovf_in = o; frame_start = fs; word_ready = rdy;
    @(negedge clock);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic o, input logic rdy);
    for (int i = 0; i < WIDTH; i++) cyc(1'b1, w[i], o, 1'b0, rdy);
  endtask

  initial begin
    int vc0;
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_en = 1'b1;
    check("reset word_out", 32'(word_out), 32'h0);
    check("reset word_valid", 32'(word_valid), 32'h0);
    check("reset word_ovf", 32'(word_ovf), 32'h0);
    check("reset lost", 32'(lost), 32'h0);
    check("reset ovf_count", 32'(ovf_count), 32'h0);
    reset = 1'b0;

    // 1,0,1,1,0,0,0,1 LSB first
    cyc(1, 1, 0, 0, 1); cyc(1, 0, 0, 0, 1); cyc(1, 1, 0, 0, 1); cyc(1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 1);
    check("no word before 8th bit", 32'(word_valid), 32'h0);
    cyc(1, 1, 0, 0, 1);
    check("first word valid", 32'(word_valid), 32'h1);
    check("first word 0x8D", 32'(word_out), 32'h8D);
    check("first word ovf", 32'(word_ovf), 32'h0);

    // Same pattern with overflow on the 4th bit
    cyc(1, 1, 0, 0, 1); cyc(1, 0, 0, 0, 1); cyc(1, 1, 0, 0, 1); cyc(1, 1, 1, 0, 1);
    cyc(1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 1);
    check("count before ovf word", 32'(ovf_count), 32'h0);
    cyc(1, 1, 0, 0, 1);
    check("ovf word 0x8D", 32'(word_out), 32'h8D);
    check("ovf word flag", 32'(word_ovf), 32'h1);
`ifdef OVF_COUNT_EN
    check("count after ovf word", 32'(ovf_count), 32'h1);
`endif

    // Backpressure: second word dropped
    cyc(0, 0, 0, 0, 1);
    send_word(8'h11, 1'b0, 1'b0);
    check("held 0x11 valid", 32'(word_valid), 32'h1);
    check("held 0x11", 32'(word_out), 32'h11);
    send_word(8'h22, 1'b0, 1'b0);
    check("lost pulse", 32'(lost), 32'h1);
    check("held word kept", 32'(word_out), 32'h11);
    cyc(0, 0, 0, 0, 0);
    check("lost one cycle", 32'(lost), 32'h0);
    check("held word stable", 32'(word_out), 32'h11);
    cyc(0, 0, 0, 0, 1);
    check("drained after ready", 32'(word_valid), 32'h0);

    // frame_start coincident with a valid bit
    vc0 = valid_cycles;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 1, 1);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 1);
    check("frame restart 0xFF", 32'(word_out), 32'hFF);
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    check("one word after restart", 32'(valid_cycles - vc0), 32'h1);

    // frame_start alone, then 0xA5
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 1);
    cyc(0, 0, 0, 1, 1);
    send_word(8'hA5, 1'b0, 1'b1);
    check("idle restart 0xA5", 32'(word_out), 32'hA5);
    check("idle restart clears ovf", 32'(word_ovf), 32'h0);

    // Reset mid-word, with other inputs active
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 1);
    reset = 1'b1;
    cyc(1, 1, 1, 1, 0);
    reset = 1'b0;
    check("mid reset word_out", 32'(word_out), 32'h0);
    check("mid reset valid", 32'(word_valid), 32'h0);
    check("mid reset lost", 32'(lost), 32'h0);
    check("mid reset count", 32'(ovf_count), 32'h0);
    send_word(8'h3C, 1'b0, 1'b1);
    check("post reset 0x3C", 32'(word_out), 32'h3C);

    // Saturation of the overflow counter
    for (int k = 0; k < 260; k++) send_word(k[WIDTH-1:0], 1'b1, 1'b1);
`ifdef OVF_COUNT_EN
    check("count saturated", 32'(ovf_count), 32'hFF);
`endif
    check("last sat word", 32'(word_out), 32'h03);
    send_word(8'h5A, 1'b1, 1'b1);
`ifdef OVF_COUNT_EN
    check("count holds", 32'(ovf_count), 32'hFF);
`endif
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
